// File: rtl/gpu_draw_scheduler_pkg.sv
// gpu_draw_scheduler_pkg: shared widths, opcodes, instruction record and FSM states
package gpu_draw_scheduler_pkg;
  localparam int WIDTH_BITS = 10;
  localparam int HEIGHT_BITS = 9;
  localparam int CHANNEL_BITS = 8;
  localparam logic [3:0] OP_LINE = 4'b0100;
  localparam logic [3:0] OP_RECT = 4'b0101;
  localparam logic [3:0] OP_CIRCLE = 4'b0110;
  localparam logic [3:0] OP_ARC = 4'b0111;
  localparam logic [3:0] OP_CLEAR = 4'b1000;
  typedef struct packed {
    logic [3:0] opcode;
    logic [WIDTH_BITS-1:0] x1;
    logic [HEIGHT_BITS-1:0] y1;
    logic [WIDTH_BITS-1:0] x2;
    logic [HEIGHT_BITS-1:0] y2;
    logic [WIDTH_BITS-1:0] rad;
    logic [2:0] oct;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } instr_t;
  localparam int INSTR_BITS = $bits(instr_t);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  function automatic logic valid_op(input logic [3:0] op);
    return op inside {OP_LINE, OP_RECT, OP_CIRCLE, OP_ARC, OP_CLEAR};
  endfunction
endpackage

// File: rtl/gpu_draw_scheduler_instr_fifo.sv
// gpu_instr_fifo: synchronous FIFO with flush; flush beats push and pop
module gpu_instr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/gpu_draw_scheduler.sv
// gpu_draw_scheduler: in-order draw issue with start/done handshake, watchdog and flush
module gpu_draw_scheduler
  import gpu_draw_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_BITS = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_instruction_i,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [2:0]              oct_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    flush_i,
  input  logic                    draw_done_i,
  output logic                    draw_start_o,
  output logic [3:0]              draw_opcode_o,
  output logic [WIDTH_BITS-1:0]   draw_x1_o,
  output logic [WIDTH_BITS-1:0]   draw_x2_o,
  output logic [WIDTH_BITS-1:0]   draw_rad_o,
  output logic [HEIGHT_BITS-1:0]  draw_y1_o,
  output logic [HEIGHT_BITS-1:0]  draw_y2_o,
  output logic [2:0]              draw_oct_o,
  output logic [CHANNEL_BITS-1:0] draw_r_o,
  output logic [CHANNEL_BITS-1:0] draw_g_o,
  output logic [CHANNEL_BITS-1:0] draw_b_o,
  output logic                    abort_o,
  output logic                    fifo_full_o,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic                    bad_opcode_o,
  output logic                    timeout_o
);
  state_t state, next;
  instr_t din, head, cur;
  logic empty, full, valid, expire;
  logic [CNT_BITS-1:0] wd_cnt;
  assign valid = valid_op(opcode_i);
  assign din = '{opcode: opcode_i, x1: x1_i, y1: y1_i, x2: x2_i, y2: y2_i, rad: rad_i, oct: oct_i, r: r_i, g: g_i, b: b_i};
  gpu_instr_fifo #(.WIDTH(INSTR_BITS), .DEPTH(FIFO_DEPTH)) fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_instruction_i && valid),
    .pop   (state == ISSUE),
    .flush (flush_i),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  assign expire = TIMEOUT_CYCLES != 0 && state == WAIT_DONE && wd_cnt == CNT_BITS'(TIMEOUT_CYCLES) && !draw_done_i;
  always_comb begin
    next = IDLE;
    abort_o = 1'b0;
    if (!flush_i) next = state == IDLE ? (empty ? IDLE : ISSUE) : state == ISSUE ? WAIT_DONE : (draw_done_i || expire) ? IDLE : WAIT_DONE;
    abort_o = !rst && state != IDLE && (flush_i || expire);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      wd_cnt <= '0;
      overflow_o <= 1'b0;
      bad_opcode_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && next == ISSUE) cur <= head;
      wd_cnt <= state == WAIT_DONE ? wd_cnt + 1'b1 : '0;
      overflow_o <= overflow_o | (push_instruction_i && valid && full && !flush_i);
      bad_opcode_o <= bad_opcode_o | (push_instruction_i && !valid);
      timeout_o <= timeout_o | expire;
    end
  end
  assign draw_start_o = state == ISSUE;
  assign busy_o = state != IDLE || !empty;
  assign fifo_full_o = full;
  assign draw_opcode_o = cur.opcode;
  assign draw_x1_o = cur.x1;
  assign draw_x2_o = cur.x2;
  assign draw_rad_o = cur.rad;
  assign draw_y1_o = cur.y1;
  assign draw_y2_o = cur.y2;
  assign draw_oct_o = cur.oct;
  assign draw_r_o = cur.r;
  assign draw_g_o = cur.g;
  assign draw_b_o = cur.b;
endmodule

// File: tb/tb_gpu_draw_scheduler.sv
// tb_gpu_draw_scheduler: timestamp-based queue model plus directed literal checks
module tb_gpu_draw_scheduler;
  import gpu_draw_scheduler_pkg::*;
  localparam int T = 16;
  logic clk = 0, rst = 1, push = 0, flush = 0, done = 0;
  logic [3:0] op = '0;
  logic [WIDTH_BITS-1:0] x1 = '0, x2 = '0, rad = '0;
  logic [HEIGHT_BITS-1:0] y1 = '0, y2 = '0;
  logic [2:0] oct = '0;
  logic [CHANNEL_BITS-1:0] r = '0, g = '0, b = '0;
  logic start, abort, full, busy, ovf, bad, tmo;
  logic [3:0] d_op;
  logic [WIDTH_BITS-1:0] d_x1, d_x2, d_rad;
  logic [HEIGHT_BITS-1:0] d_y1, d_y2;
  logic [2:0] d_oct;
  logic [CHANNEL_BITS-1:0] d_r, d_g, d_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  gpu_draw_scheduler #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(T), .CNT_BITS(13)) dut (
    .clk(clk), .rst(rst), .push_instruction_i(push), .opcode_i(op),
    .x1_i(x1), .x2_i(x2), .rad_i(rad), .y1_i(y1), .y2_i(y2), .oct_i(oct),
    .r_i(r), .g_i(g), .b_i(b), .flush_i(flush), .draw_done_i(done),
    .draw_start_o(start), .draw_opcode_o(d_op), .draw_x1_o(d_x1), .draw_x2_o(d_x2),
    .draw_rad_o(d_rad), .draw_y1_o(d_y1), .draw_y2_o(d_y2), .draw_oct_o(d_oct),
    .draw_r_o(d_r), .draw_g_o(d_g), .draw_b_o(d_b), .abort_o(abort),
    .fifo_full_o(full), .busy_o(busy), .overflow_o(ovf), .bad_opcode_o(bad), .timeout_o(tmo)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  instr_t q[$];
  int rdy[$];
  bit armed = 0, active = 0, m_ovf = 0, m_bad = 0, m_to = 0;
  int n = 0, s = 0, idle_from = 0;
  instr_t held = '0;
  always @(negedge clk) begin : model
    int sz, m;
    bit e_start, wait_ph, expire;
    sz = q.size();
    m = sz > 0 ? (idle_from > rdy[0] ? idle_from : rdy[0]) : 0;
    e_start = !active && sz > 0 && n == m + 1;
    if (e_start) begin
      held = q.pop_front();
      void'(rdy.pop_front());
      active = 1;
      s = n;
    end
    wait_ph = active && n > s;
    expire = wait_ph && n == s + 1 + T && !done;
    if (armed) begin
      chk("m_start", start, e_start);
      chk("m_abort", abort, !rst && active && (flush || expire));
      chk("m_full", full, sz == 8);
      chk("m_busy", busy, active || sz > 0);
      chk("m_overflow", ovf, m_ovf);
      chk("m_bad_opcode", bad, m_bad);
      chk("m_timeout", tmo, m_to);
      chk("m_fields", {d_op, d_x1, d_y1, d_x2, d_y2, d_rad, d_oct, d_r, d_g, d_b}, held);
    end
    if (rst) begin
      q.delete();
      rdy.delete();
      active = 0;
      m_ovf = 0;
      m_bad = 0;
      m_to = 0;
      held = '0;
      idle_from = n + 1;
      armed = 1;
    end else begin
      if (expire) m_to = 1;
      if (active && ((wait_ph && done) || flush || expire)) begin
        active = 0;
        idle_from = n + 1;
      end
      if (flush) begin
        q.delete();
        rdy.delete();
      end
      if (push) begin
        if (!(op >= 4'd4 && op <= 4'd8)) m_bad = 1;
        else if (!flush) begin
          if (sz == 8) m_ovf = 1;
          else begin
            q.push_back({op, x1, y1, x2, y2, rad, oct, r, g, b});
            rdy.push_back(n + 1);
          end
        end
      end
    end
    n++;
  end
  task automatic step();
    @(posedge clk);
    #1;
    push = 0;
    done = 0;
    flush = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask
  task automatic push_i(input logic [3:0] o, input int a, input int yb, input int c, input int d, input int rr, input int gg, input int bb);
    op = o;
    x1 = WIDTH_BITS'(a);
    y1 = HEIGHT_BITS'(yb);
    x2 = WIDTH_BITS'(c);
    y2 = HEIGHT_BITS'(d);
    rad = WIDTH_BITS'(a + 1);
    oct = 3'(a);
    r = CHANNEL_BITS'(rr);
    g = CHANNEL_BITS'(gg);
    b = CHANNEL_BITS'(bb);
    push = 1;
    step();
  endtask
  task automatic wait_start(input string nm);
    int i;
    i = 0;
    while (start !== 1'b1 && i < 40) begin
      step();
      i++;
    end
    checks++;
    if (i == 40) begin
      errors++;
      $display("FAIL %s: got no start expected start within 40 cycles", nm);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {ovf, bad, tmo, full, abort}, 0);
    chk("rst_x1", d_x1, 0);
    // single line: start two cycles after the push
    push_i(OP_LINE, 5, 7, 100, 50, 3, 2, 1);
    chk("t1_no_start_c1", start, 0);
    step();
    chk("t1_start_c2", start, 1);
    chk("t1_fields", {d_op, d_x1, d_y1, d_x2, d_y2, d_r, d_g, d_b}, {4'b0100, 10'd5, 9'd7, 10'd100, 9'd50, 8'd3, 8'd2, 8'd1});
    repeat (3) step();
    chk("t1_busy_wait", busy, 1);
    chk("t1_held_x2", d_x2, 100);
    done = 1;
    step();
    chk("t1_idle_busy", busy, 0);
    // fill while one draw is outstanding, then drain in order
    do_reset();
    push_i(OP_RECT, 100, 1, 2, 3, 4, 5, 6);
    wait_start("t2_first");
    step();
    for (int i = 0; i < 8; i++) push_i(OP_CIRCLE, i, i + 1, i + 2, i + 3, i, i, i);
    chk("t2_full", full, 1);
    chk("t2_no_ovf_yet", ovf, 0);
    push_i(OP_ARC, 50, 0, 0, 0, 0, 0, 0);
    chk("t2_overflow", ovf, 1);
    done = 1;
    step();
    chk("t2_no_start_k1", start, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("t2_start_k2", start, 1);
      chk("t2_order_x1", d_x1, i);
      step();
      step();
      done = 1;
      step();
      chk("t2_gap", start, 0);
      step();
    end
    chk("t2_drained", busy, 0);
    // invalid opcodes
    do_reset();
    push_i(4'b0011, 1, 1, 1, 1, 1, 1, 1);
    push_i(4'b1111, 2, 2, 2, 2, 2, 2, 2);
    chk("t3_bad", bad, 1);
    chk("t3_busy", busy, 0);
    step();
    step();
    chk("t3_no_start", start, 0);
    chk("t3_still_idle", busy, 0);
    // watchdog expiry, then done exactly on the expiry cycle
    do_reset();
    push_i(OP_LINE, 1, 1, 1, 1, 1, 1, 1);
    push_i(OP_CLEAR, 2, 2, 2, 2, 2, 2, 2);
    chk("t4_start_a", start, 1);
    repeat (16) step();
    chk("t4_no_abort_early", abort, 0);
    step();
    chk("t4_abort", abort, 1);
    step();
    chk("t4_timeout", tmo, 1);
    chk("t4_abort_pulse", abort, 0);
    step();
    chk("t4_start_b", start, 1);
    chk("t4_b_x1", d_x1, 2);
    repeat (17) step();
    done = 1;
    #1;
    chk("t4_done_wins", abort, 0);
    step();
    chk("t4_idle", busy, 0);
    // flush with one active and three queued, plus a push in the flush cycle
    do_reset();
    for (int i = 0; i < 4; i++) push_i(OP_RECT, 10 + i, 0, 0, 0, 0, 0, 0);
    flush = 1;
    push = 1;
    op = OP_LINE;
    #1;
    chk("t5_abort", abort, 1);
    step();
    chk("t5_busy", busy, 0);
    chk("t5_empty", full, 0);
    chk("t5_no_ovf", ovf, 0);
    repeat (6) step();
    chk("t5_no_start", start, 0);
    // reset during a wait with four queued
    do_reset();
    for (int i = 0; i < 5; i++) push_i(OP_ARC, 20 + i, 0, 0, 0, 0, 0, 0);
    rst = 1;
    step();
    rst = 0;
    chk("t6_outputs", {start, abort, full, busy, ovf, bad, tmo}, 0);
    chk("t6_fields", {d_op, d_x1, d_y1, d_x2, d_y2, d_rad, d_oct, d_r, d_g, d_b}, 0);
    done = 1;
    step();
    step();
    step();
    chk("t6_done_ignored", {start, busy}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpu_draw_scheduler.md
Name: gpu_draw_scheduler

Overview:
- Buffers draw instructions pushed by the instruction decoder in a small FIFO.
- Issues them strictly in order, one at a time, to the shared rasterizer / frame-buffer write path using a start/done handshake.
- Provides back-pressure (full), a hang watchdog and a flush path.
- Sits between the instruction decoder and the draw engines.

Parameters:
- FIFO_DEPTH, 8: instruction entries; power of two, ≥2.
- TIMEOUT_CYCLES, 4096: max cycles in WAIT_DONE before abort; 0 disables the watchdog.
- CNT_BITS, 13: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- push_instruction_i  in  1  enqueue request, one cycle per instruction.
- opcode_i  in  4  draw opcode.
- x1_i, x2_i, rad_i  in  `WIDTH_BITS  coordinates / radius.
- y1_i, y2_i  in  `HEIGHT_BITS  coordinates.
- oct_i  in  3  arc octant.
- r_i, g_i, b_i  in  `CHANNEL_BITS  colour.
- flush_i  in  1  discard queue and abort the active draw.
- draw_done_i  in  1  engine finished the current instruction (1-cycle pulse).
- draw_start_o  out  1  1-cycle pulse: draw_* fields valid, begin drawing.
- draw_opcode_o  out  4  opcode of the issued instruction.
- draw_x1_o, draw_x2_o, draw_rad_o  out  `WIDTH_BITS  issued parameters, held until the next issue.
- draw_y1_o, draw_y2_o  out  `HEIGHT_BITS  issued parameters.
- draw_oct_o  out  3  issued octant.
- draw_r_o, draw_g_o, draw_b_o  out  `CHANNEL_BITS  issued colour.
- abort_o  out  1  1-cycle pulse: engine must drop the current draw.
- fifo_full_o  out  1  count == FIFO_DEPTH.
- busy_o  out  1  state != IDLE or FIFO non-empty.
- overflow_o  out  1  sticky: a push was dropped.
- bad_opcode_o  out  1  sticky: a push carried an invalid opcode.
- timeout_o  out  1  sticky: the watchdog fired.

Behaviour:
- Reset (rst high at a clk edge):
  - FIFO empty, state IDLE.
  - All outputs 0, including sticky flags and held draw_* fields.
  - Reset overrides flush, push and done in the same cycle.
- Valid opcodes: 4'b0100 line, 0101 rect, 0110 circle, 0111 arc, 1000 clear. A push with any other opcode is not enqueued and sets bad_opcode_o.
- Full and count are from the registered count.
  - A push while full is dropped and sets overflow_o, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle when not full: both take effect, count unchanged.
- Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE: if FIFO non-empty, go to ISSUE.
  - ISSUE (exactly 1 cycle): draw_start_o=1; draw_* outputs show the head entry (registered on entry to ISSUE); pop the head; go to WAIT_DONE.
  - WAIT_DONE: draw_done_i goes to IDLE. draw_done_i is ignored in any other state.
- Latency:
  - A push in cycle 0 into an empty, idle block gives draw_start_o in cycle 2.
  - draw_done_i in cycle k with a non-empty FIFO gives the next draw_start_o in cycle k+2.
- Watchdog:
  - Counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES with no done: abort_o pulses, timeout_o sets, state goes to IDLE.
  - draw_done_i in the same cycle as expiry wins: no abort, no timeout.
- flush_i:
  - Empties the FIFO next cycle.
  - If in ISSUE or WAIT_DONE: abort_o pulses and state goes to IDLE.
  - A push in the flush cycle is discarded without setting overflow_o.
  - Sticky flags are not cleared by flush.
  - A flush in ISSUE still emits that cycle's start pulse; the abort follows in the same cycle.
- draw_* outputs hold their last issued values between issues; only draw_start_o qualifies them.

Decomposition:
- Shared definitions header gpu_definitions.vh holds:
  - Opcode constants: OP_LINE, OP_RECT, OP_CIRCLE, OP_ARC, OP_CLEAR.
  - INSTR_BITS = 4 + 3·`WIDTH_BITS + 2·`HEIGHT_BITS + 3 + 3·`CHANNEL_BITS.
  - Field offsets for packing the instruction record.
- Sub-module gpu_instr_fifo:
  - Synchronous FIFO parameterised on width and depth.
  - Ports: push, pop, flush, data in/out, full, empty.
- Scheduler module contains the FSM, watchdog and sticky flags.

Test Plan:
- Push a line (x1=5, y1=7, x2=100, y2=50, rgb=3/2/1) at cycle 0 -> draw_start_o at cycle 2 with exactly those fields; busy_o high until draw_done_i.
- Push 8 instructions back-to-back with draw_done_i held low -> fifo_full_o high after the 8th entry; a 9th push sets overflow_o; entries issue in push order as done pulses arrive, each start 2 cycles after its done.
- Push opcode 4'b0011 and 4'b1111 -> nothing enqueued, bad_opcode_o=1, busy_o stays 0.
- Set TIMEOUT_CYCLES=16 and issue with no done -> abort_o pulse 16 cycles after entering WAIT_DONE, timeout_o=1, next queued entry then issues; repeat with done on the expiry cycle -> no abort.
- 3 entries queued plus 1 active, assert flush_i -> abort_o pulse, FIFO empty, busy_o=0 the next cycle, no further starts.
- Assert rst mid-WAIT_DONE with 4 entries queued -> all outputs 0 next cycle; a later done pulse is ignored.
